// File: rtl/core_pkg.sv
// Shared pipeline-control types: forwarding-select encodings, sequencer state
// and the destination-tracking entry used by the hazard shadow pipe.
package core_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

  // rs != x0 together with rd == rs also excludes x0 destinations.
  function automatic logic src_hit(input shadow_entry_t e, input logic id_valid,
                                   input logic uses, input logic [4:0] rs);
    return id_valid && uses && (rs != 5'd0) && e.valid && e.reg_write && (e.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_load, input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit) begin
      sel = ex_load ? FWD_RF : FWD_EX_MEM;
    end else if (mem_hit) begin
      sel = FWD_MEM_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-entry shift register mirroring the destination info of the
// instructions in EX, MEM and WB; holds when the pipe is frozen.
module hazard_shadow_pipe
  import core_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_hold,
  input  logic          i_bubble,
  input  shadow_entry_t i_id_entry,
  output shadow_entry_t o_ex,
  output shadow_entry_t o_mem,
  output shadow_entry_t o_wb
);

  shadow_entry_t ex_d, ex_q;
  shadow_entry_t mem_d, mem_q;
  shadow_entry_t wb_d, wb_q;

  // Next-state: shift by one stage unless frozen
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!i_hold) begin
      ex_d  = i_bubble ? SHADOW_EMPTY : i_id_entry;
      mem_d = ex_q;
      wb_d  = mem_q;
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end
  end

  // Shadow entry registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= SHADOW_EMPTY;
      mem_q <= SHADOW_EMPTY;
      wb_q  <= SHADOW_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign o_ex  = ex_q;
  assign o_mem = mem_q;
  assign o_wb  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage pipeline sequencer: stalls, flushes, bubbles, freezes and forwarding selects.
// Define HAZARD_CTRL_FORWARD_EN to enable EX/MEM and MEM/WB forwarding (load-use stall only).
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_id_valid,
  input  logic [4:0]             i_id_rs1_raddr,
  input  logic [4:0]             i_id_rs2_raddr,
  input  logic                   i_id_uses_rs1,
  input  logic                   i_id_uses_rs2,
  input  logic [4:0]             i_id_rd,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_mem_read,
  input  logic                   i_ex_redirect,
  input  logic                   i_imem_ready,
  input  logic                   i_dmem_req,
  input  logic                   i_dmem_ready,
  output logic                   o_pc_en,
  output logic                   o_ifid_en,
  output logic                   o_ifid_flush,
  output logic                   o_idex_bubble,
  output logic                   o_pipe_en,
  output logic [1:0]             o_fwd_rs1_sel,
  output logic [1:0]             o_fwd_rs2_sel,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  pipe_state_e             state_d, state_q;
  logic [STALL_CNT_W-1:0]  cnt_d, cnt_q;
  shadow_entry_t           id_entry_s, ex_s, mem_s, wb_s;
  logic                    freeze_s, raw_s;
  logic                    pc_en_s, ifid_en_s, flush_s, bubble_s, pipe_en_s;
  logic [1:0]              fwd1_s, fwd2_s;
  logic                    unused_s;

  // Decode-stage destination info entering the shadow pipe
  always_comb begin
    id_entry_s           = SHADOW_EMPTY;
    id_entry_s.valid     = i_id_valid;
    id_entry_s.rd        = i_id_rd;
    id_entry_s.reg_write = i_id_reg_write;
    id_entry_s.mem_read  = i_id_mem_read;
  end

  hazard_shadow_pipe u_shadow (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_hold     (!pipe_en_s),
    .i_bubble   (bubble_s),
    .i_id_entry (id_entry_s),
    .o_ex       (ex_s),
    .o_mem      (mem_s),
    .o_wb       (wb_s)
  );

  logic hit1_ex_s, hit2_ex_s, hit1_mem_s, hit2_mem_s;
  assign hit1_ex_s  = src_hit(ex_s,  i_id_valid, i_id_uses_rs1, i_id_rs1_raddr);
  assign hit2_ex_s  = src_hit(ex_s,  i_id_valid, i_id_uses_rs2, i_id_rs2_raddr);
  assign hit1_mem_s = src_hit(mem_s, i_id_valid, i_id_uses_rs1, i_id_rs1_raddr);
  assign hit2_mem_s = src_hit(mem_s, i_id_valid, i_id_uses_rs2, i_id_rs2_raddr);

`ifdef HAZARD_CTRL_FORWARD_EN
  // WB results reach decode through the write-first register file, so WB is never consulted.
  assign raw_s    = ex_s.mem_read && (hit1_ex_s || hit2_ex_s);
  assign fwd1_s   = fwd_sel(hit1_ex_s, ex_s.mem_read, hit1_mem_s);
  assign fwd2_s   = fwd_sel(hit2_ex_s, ex_s.mem_read, hit2_mem_s);
  assign unused_s = ^{wb_s, mem_s.mem_read};
`else
  logic hit1_wb_s, hit2_wb_s;
  assign hit1_wb_s = src_hit(wb_s, i_id_valid, i_id_uses_rs1, i_id_rs1_raddr);
  assign hit2_wb_s = src_hit(wb_s, i_id_valid, i_id_uses_rs2, i_id_rs2_raddr);
  assign raw_s     = hit1_ex_s || hit2_ex_s || hit1_mem_s || hit2_mem_s || hit1_wb_s || hit2_wb_s;
  assign fwd1_s    = FWD_RF;
  assign fwd2_s    = FWD_RF;
  assign unused_s  = ^{ex_s.mem_read, mem_s.mem_read, wb_s.mem_read};
`endif

  // Once a dmem wait has started it is held until the access completes.
  assign freeze_s = !i_dmem_ready && (i_dmem_req || (state_q == ST_MEM_WAIT));

  // Prioritised enable generation: freeze, redirect, RAW stall, fetch miss, run
  always_comb begin
    pc_en_s   = 1'b1;
    ifid_en_s = 1'b1;
    flush_s   = 1'b0;
    bubble_s  = 1'b0;
    pipe_en_s = 1'b1;
    if (freeze_s) begin
      pc_en_s   = 1'b0;
      ifid_en_s = 1'b0;
      pipe_en_s = 1'b0;
    end else if (i_ex_redirect) begin
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (raw_s) begin
      pc_en_s   = 1'b0;
      ifid_en_s = 1'b0;
      bubble_s  = 1'b1;
    end else if (!i_imem_ready) begin
      pc_en_s = 1'b0;
      flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // Sequencer state and saturating stall counter next-state
  always_comb begin
    state_d = freeze_s ? ST_MEM_WAIT : ST_RUN;
    if (!pc_en_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sequencer state and stall counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces the pipe idle with NOPs loaded, independent of tracked state.
  assign o_pc_en       = i_rst_n && pc_en_s;
  assign o_ifid_en     = i_rst_n && ifid_en_s;
  assign o_ifid_flush  = !i_rst_n || flush_s;
  assign o_idex_bubble = !i_rst_n || bubble_s;
  assign o_pipe_en     = i_rst_n && pipe_en_s;
  assign o_fwd_rs1_sel = i_rst_n ? fwd1_s : FWD_RF;
  assign o_fwd_rs2_sel = i_rst_n ? fwd2_s : FWD_RF;
  assign o_stall_cnt   = cnt_q;

endmodule
